// File: rtl/calc_sequencer_pkg.sv
// Shared types and constants for the calculator sequencer: state encoding,
// operator and error codes, display limits and the default operand width.
package calc_sequencer_pkg;

    // Default operand width (signed two's complement).
    localparam int unsigned InputOutBit = 16;

    typedef enum logic [2:0] {
        StGetA  = 3'd0,
        StGetOp = 3'd1,
        StGetB  = 3'd2,
        StExec  = 3'd3,
        StWait  = 3'd4,
        StShow  = 3'd5,
        StErr   = 3'd6
    } calc_state_e;

    // Operator codes presented on alu_op.
    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpMul = 2'd2;
    localparam logic [1:0] OpDiv = 2'd3;

    // Error codes presented on err_code.
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrDiv0    = 2'd1;
    localparam logic [1:0] ErrRange   = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    // Display prompt codes presented on stage.
    localparam logic [1:0] StageA      = 2'd0;
    localparam logic [1:0] StageOp     = 2'd1;
    localparam logic [1:0] StageB      = 2'd2;
    localparam logic [1:0] StageResult = 2'd3;

    // Range of the 3-digit signed display.
    localparam int DispMax = 999;
    localparam int DispMin = -999;

    // Entry prompt shown for each state; EXEC and WAIT already show the result slot.
    function automatic logic [1:0] stage_of(calc_state_e s);
        case (s)
            StGetA:  return StageA;
            StGetOp: return StageOp;
            StGetB:  return StageB;
            default: return StageResult;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_wait_timer.sv
// Cycle counter bounding how long the sequencer waits for the arithmetic unit.
// The launch cycle (where clear is high) counts as the first of TIMEOUT cycles,
// so expired pulses in the last waiting cycle and the error shows exactly
// TIMEOUT cycles after the launch.
module wait_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT - 2);

    logic [CntW-1:0] count_q, count_d;

    // Restart on launch, advance while waiting, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == LastCount);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects A, operator and B from digit entry, launches
// one operation on the shared arithmetic unit, range-checks the result against
// the 3-digit display and presents either the result or an error code.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int unsigned W       = InputOutBit,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           input_done,
    input  logic [W-1:0]   input_val,
    input  logic           btn_clear,
    output logic           alu_start,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_op,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result,
    output logic [1:0]     stage,
    output logic [W-1:0]   result,
    output logic           result_valid,
    output logic           err,
    output logic [1:0]     err_code,
    output logic           op_reject
);

    localparam logic signed [2*W-1:0] RangeMax = (2*W)'(DispMax);
    localparam logic signed [2*W-1:0] RangeMin = (2*W)'(DispMin);

    calc_state_e    state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;
    logic           op_reject_q, op_reject_d;

    logic           op_legal;
    logic           div_by_zero;
    logic           in_range;
    logic           timer_clear;
    logic           timer_enable;
    logic           timer_expired;

    // Operator codes are 0..3; anything negative or larger is rejected.
    assign op_legal     = (input_val[W-1:2] == '0);
    assign div_by_zero  = (op_q == OpDiv) && (b_q == '0);
    // Checked on the full-width result so the low W bits are lossless afterwards.
    assign in_range     = ($signed(alu_result) <= RangeMax) &&
                          ($signed(alu_result) >= RangeMin);

    assign timer_clear  = (state_q == StExec);
    assign timer_enable = (state_q == StWait);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state, operand capture, result/error capture.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        err_code_d  = err_code_q;
        op_reject_d = 1'b0;

        if (btn_clear) begin
            // Clear wins over any coincident input_done or alu_done.
            state_d = StGetA;
        end else begin
            unique case (state_q)
                StGetA: begin
                    if (input_done) begin
                        a_d     = input_val;
                        state_d = StGetOp;
                    end
                end
                StGetOp: begin
                    if (input_done) begin
                        if (op_legal) begin
                            op_d    = input_val[1:0];
                            state_d = StGetB;
                        end else begin
                            op_reject_d = 1'b1;
                        end
                    end
                end
                StGetB: begin
                    if (input_done) begin
                        b_d     = input_val;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (div_by_zero) begin
                        err_code_d = ErrDiv0;
                        state_d    = StErr;
                    end else begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    // A done in the expiry cycle still counts.
                    if (alu_done) begin
                        if (in_range) begin
                            result_d = alu_result[W-1:0];
                            state_d  = StShow;
                        end else begin
                            err_code_d = ErrRange;
                            state_d    = StErr;
                        end
                    end else if (timer_expired) begin
                        err_code_d = ErrTimeout;
                        state_d    = StErr;
                    end
                end
                StShow, StErr: begin
                    if (input_done) begin
                        a_d     = input_val;
                        state_d = StGetOp;
                    end
                end
                default: begin
                    state_d = StGetA;
                end
            endcase
        end

        // Result and error are only held while their state is occupied.
        if (state_d != StShow) begin
            result_d = '0;
        end
        if (state_d != StErr) begin
            err_code_d = ErrNone;
        end
        result_valid_d = (state_d == StShow);
        err_d          = (state_d == StErr);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StGetA;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= OpAdd;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ErrNone;
            op_reject_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            op_reject_q    <= op_reject_d;
        end
    end

    // A clear in the launch cycle suppresses the launch so nothing is left in flight.
    assign alu_start    = (state_q == StExec) && !div_by_zero && !btn_clear;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign stage        = stage_of(state_q);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign op_reject    = op_reject_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios followed by randomized
// transactions, each outcome predicted from the arithmetic itself.
module tb_calc_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           input_done = 1'b0;
    logic [W-1:0]   input_val = '0;
    logic           btn_clear = 1'b0;
    logic           alu_start;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [1:0]     alu_op;
    logic           alu_done = 1'b0;
    logic [2*W-1:0] alu_result = '0;
    logic [1:0]     stage;
    logic [W-1:0]   result;
    logic           result_valid;
    logic           err;
    logic [1:0]     err_code;
    logic           op_reject;

    int n_cmp = 0;
    int n_bad = 0;
    int step  = 0;

    calc_sequencer #(
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_done   (input_done),
        .input_val    (input_val),
        .btn_clear    (btn_clear),
        .alu_start    (alu_start),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .stage        (stage),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .err_code     (err_code),
        .op_reject    (op_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (step %0d): observed %0d expected %0d", tag, step, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        input_done = 1'b1;
        input_val  = v[W-1:0];
        tick();
        input_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu_start"}, alu_start, 0);
        chk({tag, ".alu_a"}, alu_a, 0);
        chk({tag, ".alu_b"}, alu_b, 0);
        chk({tag, ".alu_op"}, alu_op, 0);
        chk({tag, ".stage"}, stage, 0);
        chk({tag, ".result"}, result, 0);
        chk({tag, ".result_valid"}, result_valid, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".err_code"}, err_code, 0);
        chk({tag, ".op_reject"}, op_reject, 0);
    endtask

    // What an ideal arithmetic unit produces for the operands.
    function automatic longint arith(input int a, input int op, input int b);
        case (op)
            0: return longint'(a) + longint'(b);
            1: return longint'(a) - longint'(b);
            2: return longint'(a) * longint'(b);
            default: return longint'(a) / longint'(b);
        endcase
    endfunction

    // One full transaction from A entry to SHOW/ERR; k is the cycle after the
    // launch on which the ALU answers (k > TO-1 means it never answers).
    task automatic run_op(input int a, input int op, input int b, input int k,
                          input bit bad, input int bad_val);
        longint r;
        logic [63:0] r_bits;
        step++;
        send(a);
        chk("a_stage", stage, 1);
        chk("a_err_cleared", err, 0);
        chk("a_err_code_cleared", err_code, 0);
        chk("a_result_valid", result_valid, 0);
        chk("a_latched", $signed(alu_a), a);
        if (bad) begin
            send(bad_val);
            chk("op_reject_pulse", op_reject, 1);
            chk("op_reject_stage", stage, 1);
            tick();
            chk("op_reject_single", op_reject, 0);
        end
        send(op);
        chk("op_stage", stage, 2);
        chk("op_latched", alu_op, op);
        send(b);
        chk("exec_stage", stage, 3);
        if (op == 3 && b == 0) begin
            chk("div0_no_start", alu_start, 0);
            tick();
            chk("div0_err", err, 1);
            chk("div0_code", err_code, 1);
            chk("div0_result_valid", result_valid, 0);
            chk("div0_no_start_after", alu_start, 0);
            return;
        end
        chk("exec_start", alu_start, 1);
        chk("exec_a", $signed(alu_a), a);
        chk("exec_b", $signed(alu_b), b);
        chk("exec_op", alu_op, op);
        r = arith(a, op, b);
        r_bits = r;
        tick();
        chk("start_single", alu_start, 0);
        if (k <= int'(TO) - 1) begin
            repeat (k - 1) tick();
            chk("wait_result_valid", result_valid, 0);
            chk("wait_err", err, 0);
            chk("wait_b_stable", $signed(alu_b), b);
            alu_done   = 1'b1;
            alu_result = r_bits[2*W-1:0];
            tick();
            alu_done   = 1'b0;
            alu_result = 32'hdead_beef;
            if (r >= -999 && r <= 999) begin
                chk("show_valid", result_valid, 1);
                chk("show_result", $signed(result), r);
                chk("show_stage", stage, 3);
                chk("show_err", err, 0);
            end else begin
                chk("range_err", err, 1);
                chk("range_code", err_code, 2);
                chk("range_result_valid", result_valid, 0);
                chk("range_result", result, 0);
            end
        end else begin
            repeat (TO - 2) tick();
            chk("timeout_not_yet", err, 0);
            tick();
            chk("timeout_err", err, 1);
            chk("timeout_code", err_code, 3);
            chk("timeout_result_valid", result_valid, 0);
            alu_done   = 1'b1;
            alu_result = r_bits[2*W-1:0];
            tick();
            alu_done   = 1'b0;
            chk("stray_done_code", err_code, 3);
            chk("stray_done_valid", result_valid, 0);
        end
    endtask

    function automatic int rand_operand();
        case ($urandom_range(0, 2))
            0: return int'($urandom_range(0, 60)) - 30;
            1: return int'($urandom_range(0, 2400)) - 1200;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int a, b, op, k, bv;
        bit bad;

        #3;
        chk_all_zero("reset");
        #9 rst_n = 1'b1;
        tick();
        chk_all_zero("after_reset");

        // Directed scenarios.
        run_op(12, 0, -30, 2, 1'b0, 0);
        run_op(5, 3, 0, 1, 1'b0, 0);
        run_op(999, 2, 2, 1, 1'b0, 0);
        run_op(3, 1, 1, 1, 1'b1, 7);
        run_op(100, 0, 1, 99, 1'b0, 0);
        run_op(4, 1, 9, 3, 1'b1, -2);
        run_op(-999, 1, 0, 7, 1'b0, 0);
        run_op(-500, 1, 500, 1, 1'b0, 0);

        // Reset in the middle of a wait.
        step++;
        send(20);
        send(1);
        send(5);
        chk("rst_start", alu_start, 1);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid_wait");
        #2 rst_n = 1'b1;
        tick();
        chk("rst_stage", stage, 0);

        // Clear coincident with input_done in SHOW.
        run_op(1, 0, 2, 1, 1'b0, 0);
        step++;
        btn_clear  = 1'b1;
        input_done = 1'b1;
        input_val  = 16'd55;
        tick();
        btn_clear  = 1'b0;
        input_done = 1'b0;
        chk("clr_stage", stage, 0);
        chk("clr_result_valid", result_valid, 0);
        chk("clr_result", result, 0);
        chk("clr_err", err, 0);
        chk("clr_keeps_a", $signed(alu_a), 1);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            a   = rand_operand();
            b   = ($urandom_range(0, 5) == 0) ? 0 : rand_operand();
            op  = int'($urandom_range(0, 3));
            k   = int'($urandom_range(1, 9));
            bad = ($urandom_range(0, 4) == 0);
            bv  = $urandom_range(0, 1) ? int'($urandom_range(4, 500))
                                       : -int'($urandom_range(1, 50));
            if ($urandom_range(0, 5) == 0) begin
                btn_clear = 1'b1;
                tick();
                btn_clear = 1'b0;
                chk("rand_clear_stage", stage, 0);
                chk("rand_clear_err", err, 0);
                chk("rand_clear_valid", result_valid, 0);
            end
            run_op(a, op, b, k, bad, bv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level sequencer for the calculator datapath. It collects operand A, an operator code and operand B from successive `input_done` pulses of the digit-entry controller, and launches one operation on the shared arithmetic unit with a start/done handshake. It range-checks the result against the 3-digit display and presents either the result or an error code to the display driver. It sits between the digit-entry controller, the arithmetic unit and the seven-segment display mux.

## Interface
- `W`, default `` `INPUTOUTBIT `` (from `define.vh`): operand width, signed two's complement.
- `TIMEOUT`, default 1024: maximum cycles to wait for `alu_done` before declaring an error.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `input_done`  in  1  one-cycle pulse: `input_val` is valid this cycle.
- `input_val`  in  W  signed value from digit entry.
- `btn_clear`  in  1  one-cycle pulse: abort and return to operand-A entry.
- `alu_start`  out  1  one-cycle launch pulse to the arithmetic unit.
- `alu_a`, `alu_b`  out  W each  latched operands, held stable from `alu_start` until `alu_done`.
- `alu_op`  out  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- `alu_done`  in  1  one-cycle pulse: `alu_result` is valid this cycle.
- `alu_result`  in  2W  signed result.
- `stage`  out  2  entry prompt for the display: 0 A, 1 op, 2 B, 3 result or error.
- `result`  out  W  signed result; valid while `result_valid` is high.
- `result_valid`  out  1  high in SHOW.
- `err`  out  1  high in ERR.
- `err_code`  out  2  error code: 1 divide-by-zero, 2 out of range, 3 timeout; 0 when `err` is low.
- `op_reject`  out  1  one-cycle pulse: the operator code entered was illegal.

## Operation
- States: GET_A, GET_OP, GET_B, EXEC, WAIT, SHOW, ERR. Reset state is GET_A.
- GET_A:
  - `input_done` latches `alu_a`, then go to GET_OP.
- GET_OP:
  - `input_done` with `input_val` in 0..3 latches `alu_op`, then go to GET_B.
  - Any other value: stay in GET_OP and pulse `op_reject` on the next cycle.
- GET_B:
  - `input_done` latches `alu_b`, then go to EXEC.
- EXEC (one cycle):
  - If `alu_op`=3 and `alu_b`=0: go to ERR with code 1. No `alu_start` is issued.
  - Otherwise: assert `alu_start`, clear the timeout counter, go to WAIT.
- WAIT:
  - On `alu_done`: if `alu_result` is in -999..999, register it into `result` and go to SHOW; otherwise go to ERR with code 2.
  - If the counter reaches `TIMEOUT`-1 without `alu_done`: go to ERR with code 3.
  - `alu_done` and timeout in the same cycle: `alu_done` wins.
- SHOW:
  - `input_done` chains: latches a new `alu_a`, goes to GET_OP.
  - `result` and `result_valid` drop when leaving SHOW.
- ERR:
  - `input_done` behaves as in GET_A (new `alu_a`, go to GET_OP) and clears `err`/`err_code`.
- `btn_clear` in any state:
  - Go to GET_A and clear `result`, `result_valid`, `err`, `err_code`.
  - Latched operands are not cleared.
  - Has priority over `input_done` and `alu_done` in the same cycle.
  - In WAIT, a later stray `alu_done` is ignored outside WAIT.
- `input_done` in EXEC or WAIT is ignored.
- `alu_done` in any state other than WAIT is ignored.
- Reset values:
  - `alu_start`, `alu_a`, `alu_b`, `alu_op`, `result`, `result_valid`, `err`, `err_code`, `op_reject`, timeout counter: 0.
  - `stage`: 0 (GET_A).
- Width rules:
  - The range check is done on the full 2W-bit signed result.
  - `result` is the low W bits, which is lossless after the check.

## Timing
- Every transition happens on the edge where the triggering pulse is sampled. The new state is visible the following cycle.
- `alu_start` is asserted during the single cycle spent in EXEC, which is the cycle after the GET_B capture.
- `result_valid` rises the cycle after `alu_done` is sampled.
- Minimum latency from the B `input_done` to `result_valid` is 3 cycles, with `alu_done` returning the cycle after `alu_start`.
- The timeout fires exactly `TIMEOUT` cycles after `alu_start`.
- `rst_n` asserted mid-operation returns all outputs to reset values immediately. Any ALU operation in flight is abandoned.

## Structure
- Shared header `define.vh` holds:
  - state encodings;
  - operator codes `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_DIV`;
  - error codes `ERR_DIV0`/`ERR_RANGE`/`ERR_TIMEOUT`;
  - display limits `DISP_MAX`=999 and `DISP_MIN`=-999;
  - `INPUTOUTBIT`.
- One sub-module, `wait_timer`, sized from `TIMEOUT`:
  - inputs: `clear`, `enable`;
  - output: a one-cycle `expired` pulse.
- The FSM, operand latches and range check stay in `calc_sequencer`.

## Test plan
- A=12, op=0, B=-30, ALU returns -18 after 2 cycles: `alu_start` pulses once with a=12, b=-30, op=0; `result`=-18 and `result_valid`=1 one cycle after `alu_done`; `stage`=3.
- A=5, op=3, B=0: ERR with `err_code`=1 two cycles after the B capture; `alu_start` never asserts.
- A=999, op=2, B=2, ALU returns 1998: ERR with `err_code`=2; `result_valid` stays 0.
- Op entry value 7 then 1: `op_reject` pulses once and the state remains GET_OP; the value 1 is accepted and `stage` becomes 2.
- `TIMEOUT`=8, `alu_done` never arrives: `err_code`=3 eight cycles after `alu_start`; a later `alu_done` is ignored; the next `input_done`=4 sets `alu_a`=4 and the state goes to GET_OP.
- `rst_n` low during WAIT, then `btn_clear` and `input_done` coincident in SHOW: all outputs return to 0; `btn_clear` wins and `stage`=0.
